// File: rtl/delivery_sequencer_if.sv
// Scorer-to-sequencer delivery entry handshake.
// The scorer side is the master and the delivery_sequencer side is the slave.
interface delivery_sequencer_if;
    logic       entry_valid;
    logic       entry_ready;
    logic [2:0] entry_runs;
    logic       entry_wide;
    logic       entry_noball;
    logic       entry_wicket;
    logic       entry_err;

    modport master (
        output entry_valid, entry_runs, entry_wide, entry_noball, entry_wicket,
        input  entry_ready, entry_err
    );

    modport slave (
        input  entry_valid, entry_runs, entry_wide, entry_noball, entry_wicket,
        output entry_ready, entry_err
    );
endinterface

// File: rtl/delivery_sequencer.sv
// Buffers scorer entries and issues one ball_bowled pulse per delivery; tracks overs and innings.
// Optional FREE_HIT_EN: free-hit tracking after no-balls, with an extra free_hit output.
module delivery_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 2,
    parameter int MAX_OVERS  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    delivery_sequencer_if.slave  entry,
    output logic                 ball_bowled,
    output logic [2:0]           runs,
    output logic                 wicket,
    output logic [2:0]           ball_in_over,
    output logic [7:0]           over_count,
    output logic                 over_complete,
    output logic                 innings_done
`ifdef FREE_HIT_EN
    ,
    output logic                 free_hit
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [GW-1:0] gap_cnt;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [5:0]    mem [FIFO_DEPTH];

    logic       fifo_empty;
    logic       fifo_full;
    logic       bad_entry;
    logic       accept;
    logic       push;
    logic       reject;
    logic [2:0] pen_runs;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign entry.entry_ready = !reset && !fifo_full && !innings_done && (state != DONE);

    assign bad_entry = (entry.entry_runs == 3'd7) || (entry.entry_wide && entry.entry_noball);
    assign accept    = entry.entry_valid && entry.entry_ready;
    assign push      = accept && !bad_entry;
    assign reject    = (accept && bad_entry) || (entry.entry_valid && (state == DONE));
    assign pen_runs  = entry.entry_runs + {2'b00, entry.entry_wide | entry.entry_noball};

    // Entry layout: {runs incl. penalty, wicket, wide, noball}
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {pen_runs, entry.entry_wicket, entry.entry_wide, entry.entry_noball};
    end

    logic [5:0] head;
    logic [2:0] head_runs;
    logic       head_wicket;
    logic       head_legal;
    logic       head_noball;
    logic       last_ball;
    logic [7:0] over_next;
    logic       innings_end;
    logic       more_queued;

    assign head        = mem[rd_ptr[AW-1:0]];
    assign head_runs   = head[5:3];
    assign head_wicket = head[2];
    assign head_noball = head[0];
    assign head_legal  = !head[1] && !head[0];
    assign last_ball   = head_legal && (ball_in_over == 3'd5);
    assign over_next   = over_count + 8'(last_ball);
    assign innings_end = last_ball && (over_next == 8'(MAX_OVERS));
    assign more_queued = ((rd_ptr + PTR_ONE) != wr_ptr);

`ifdef FREE_HIT_EN
    logic fh_flag;
`endif

    // Delivery outputs are registered on the edge that ends the ISSUE cycle,
    // so a reset inside ISSUE suppresses the pulse and every counter update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ball_bowled   <= 1'b0;
            runs          <= '0;
            wicket        <= 1'b0;
            ball_in_over  <= '0;
            over_count    <= '0;
            over_complete <= 1'b0;
            innings_done  <= 1'b0;
            entry.entry_err <= 1'b0;
`ifdef FREE_HIT_EN
            fh_flag       <= 1'b0;
            free_hit      <= 1'b0;
`endif
        end else begin
            ball_bowled     <= 1'b0;
            runs            <= '0;
            wicket          <= 1'b0;
            over_complete   <= 1'b0;
            entry.entry_err <= reject;
`ifdef FREE_HIT_EN
            free_hit        <= 1'b0;
`endif
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;

            case (state)
                IDLE: begin
                    if (!fifo_empty)
                        state <= ISSUE;
                end
                ISSUE: begin
                    rd_ptr      <= rd_ptr + PTR_ONE;
                    ball_bowled <= 1'b1;
                    runs        <= head_runs;
`ifdef FREE_HIT_EN
                    wicket   <= head_wicket && !fh_flag;
                    free_hit <= fh_flag;
                    if (head_noball)
                        fh_flag <= 1'b1;
                    else if (head_legal)
                        fh_flag <= 1'b0;
`else
                    wicket   <= head_wicket;
`endif
                    if (head_legal)
                        ball_in_over <= last_ball ? 3'd0 : ball_in_over + 3'd1;
                    if (last_ball) begin
                        over_count    <= over_next;
                        over_complete <= 1'b1;
                    end
                    if (innings_end) begin
                        innings_done <= 1'b1;
                        state        <= DONE;
                    end else if (ISSUE_GAP > 0) begin
                        gap_cnt <= GW'(ISSUE_GAP - 1);
                        state   <= GAP;
                    end else begin
                        state <= more_queued ? ISSUE : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= fifo_empty ? IDLE : ISSUE;
                    else
                        gap_cnt <= gap_cnt - GW'(1);
                end
                default: begin
                    // Terminal: anything still queued is discarded
                    rd_ptr <= wr_ptr;
                end
            endcase
        end
    end

`ifndef FREE_HIT_EN
    logic unused_noball;
    assign unused_noball = head_noball;
`endif

endmodule

// File: tb/tb_delivery_sequencer.sv
// Directed bench for delivery_sequencer: three instances cover the default build,
// a one-over innings and a long issue gap for FIFO back-pressure.
module tb_delivery_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    delivery_sequencer_if b0 ();
    delivery_sequencer_if b1 ();
    delivery_sequencer_if b2 ();

    logic       bb  [3];
    logic [2:0] rn  [3];
    logic       wk  [3];
    logic [2:0] bio [3];
    logic [7:0] oc  [3];
    logic       ocp [3];
    logic       idn [3];
`ifdef FREE_HIT_EN
    logic       fh  [3];
`endif

    delivery_sequencer #(.FIFO_DEPTH(4), .ISSUE_GAP(2), .MAX_OVERS(20)) dut0 (
        .clk(clk), .reset(reset), .entry(b0),
        .ball_bowled(bb[0]), .runs(rn[0]), .wicket(wk[0]), .ball_in_over(bio[0]),
        .over_count(oc[0]), .over_complete(ocp[0]), .innings_done(idn[0])
`ifdef FREE_HIT_EN
        , .free_hit(fh[0])
`endif
    );

    delivery_sequencer #(.FIFO_DEPTH(4), .ISSUE_GAP(2), .MAX_OVERS(1)) dut1 (
        .clk(clk), .reset(reset), .entry(b1),
        .ball_bowled(bb[1]), .runs(rn[1]), .wicket(wk[1]), .ball_in_over(bio[1]),
        .over_count(oc[1]), .over_complete(ocp[1]), .innings_done(idn[1])
`ifdef FREE_HIT_EN
        , .free_hit(fh[1])
`endif
    );

    delivery_sequencer #(.FIFO_DEPTH(4), .ISSUE_GAP(12), .MAX_OVERS(20)) dut2 (
        .clk(clk), .reset(reset), .entry(b2),
        .ball_bowled(bb[2]), .runs(rn[2]), .wicket(wk[2]), .ball_in_over(bio[2]),
        .over_count(oc[2]), .over_complete(ocp[2]), .innings_done(idn[2])
`ifdef FREE_HIT_EN
        , .free_hit(fh[2])
`endif
    );

    typedef struct {
        int         cyc;
        logic [2:0] runs;
        logic       wk;
        logic [2:0] bio;
        logic [7:0] oc;
        logic       ocomp;
        logic       idone;
        logic       fhit;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];
    int  errs [3];

    function automatic ev_t mk_ev(input int i);
        ev_t e;
        e.cyc   = cyc;
        e.runs  = rn[i];
        e.wk    = wk[i];
        e.bio   = bio[i];
        e.oc    = oc[i];
        e.ocomp = ocp[i];
        e.idone = idn[i];
`ifdef FREE_HIT_EN
        e.fhit  = fh[i];
`else
        e.fhit  = 1'b0;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (bb[0] === 1'b1) q0.push_back(mk_ev(0));
        if (bb[1] === 1'b1) q1.push_back(mk_ev(1));
        if (bb[2] === 1'b1) q2.push_back(mk_ev(2));
        if (b0.entry_err === 1'b1) errs[0]++;
        if (b1.entry_err === 1'b1) errs[1]++;
        if (b2.entry_err === 1'b1) errs[2]++;
    end

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic ev_t get_ev(input int d, input int idx);
        ev_t e;
        e = '{default: 0};
        if (idx < qsize(d)) begin
            case (d)
                0:       e = q0[idx];
                1:       e = q1[idx];
                default: e = q2[idx];
            endcase
        end
        return e;
    endfunction

    function automatic logic rdy(input int d);
        case (d)
            0:       return b0.entry_ready;
            1:       return b1.entry_ready;
            default: return b2.entry_ready;
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic [2:0] r,
                         input logic w, input logic n, input logic k);
        case (d)
            0: begin b0.entry_valid = v; b0.entry_runs = r; b0.entry_wide = w; b0.entry_noball = n; b0.entry_wicket = k; end
            1: begin b1.entry_valid = v; b1.entry_runs = r; b1.entry_wide = w; b1.entry_noball = n; b1.entry_wicket = k; end
            default: begin b2.entry_valid = v; b2.entry_runs = r; b2.entry_wide = w; b2.entry_noball = n; b2.entry_wicket = k; end
        endcase
    endtask

    // Offer an entry and hold it until accepted; acc_cyc is the accept edge count.
    task automatic push(input int d, input logic [2:0] r, input logic w, input logic n,
                        input logic k, output int acc_cyc, output int waits);
        @(negedge clk);
        drive(d, 1'b1, r, w, n, k);
        waits = 0;
        while (!rdy(d) && waits < 80) begin
            @(negedge clk);
            waits++;
        end
        total++;
        if (!rdy(d)) begin
            bad++;
            $display("FAIL push_timeout dut=%0d entry_ready=0 required=1", d);
            drive(d, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            acc_cyc = -1;
        end else begin
            @(posedge clk);
            #1;
            drive(d, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            acc_cyc = cyc;
        end
    endtask

    task automatic offer(input int d, input logic [2:0] r, input logic w, input logic n, input logic k);
        @(negedge clk);
        drive(d, 1'b1, r, w, n, k);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_events(input int d, input int n);
        int t;
        t = 0;
        while (qsize(d) < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (qsize(d) < n) begin
            bad++;
            $display("FAIL wait_pulses dut=%0d got=%0d required=%0d", d, qsize(d), n);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        for (int unsigned i = 0; i < 3; i++) drive(int'(i), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        q0.delete(); q1.delete(); q2.delete();
        errs[0] = 0; errs[1] = 0; errs[2] = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [19:0] outs;
        @(negedge clk);
        reset = 1'b1;
        #2;
        outs = {bb[0], rn[0], wk[0], bio[0], oc[0], ocp[0], idn[0], b0.entry_err, b0.entry_ready};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0", outs);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({b0.entry_ready, b1.entry_ready, b2.entry_ready} !== 3'b111) begin
            bad++;
            $display("FAIL reset_ready got=%b required=111", {b0.entry_ready, b1.entry_ready, b2.entry_ready});
        end
    endtask

    task automatic test_reset_abort;
        int a, w;
        do_reset;
        push(0, 3'd5, 1'b0, 1'b0, 1'b0, a, w);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (qsize(0) != 0 || bio[0] !== 3'd0) begin
            bad++;
            $display("FAIL reset_abort pulses=%0d bio=%0d required pulses=0 bio=0", qsize(0), bio[0]);
        end
    endtask

    task automatic test_legal;
        int a[4];
        int w, sum;
        logic [2:0] exp_r[4];
        exp_r = '{3'd4, 3'd6, 3'd1, 3'd0};
        do_reset;
        for (int i = 0; i < 4; i++) push(0, exp_r[i], 1'b0, 1'b0, 1'b0, a[i], w);
        wait_events(0, 4);
        total++;
        if (get_ev(0, 0).cyc - a[0] != 2) begin
            bad++;
            $display("FAIL latency got=%0d required=2", get_ev(0, 0).cyc - a[0]);
        end
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            sum += int'(get_ev(0, i).runs);
            total++;
            if (get_ev(0, i).runs !== exp_r[i]) begin
                bad++;
                $display("FAIL legal_runs idx=%0d got=%0d required=%0d", i, get_ev(0, i).runs, exp_r[i]);
            end
            if (i > 0) begin
                total++;
                if (get_ev(0, i).cyc - get_ev(0, i - 1).cyc != 3) begin
                    bad++;
                    $display("FAIL spacing idx=%0d got=%0d required=3", i, get_ev(0, i).cyc - get_ev(0, i - 1).cyc);
                end
            end
        end
        total++;
        if (sum != 11) begin
            bad++;
            $display("FAIL run_total got=%0d required=11", sum);
        end
        total++;
        if (bio[0] !== 3'd4 || oc[0] !== 8'd0) begin
            bad++;
            $display("FAIL legal_counts bio=%0d oc=%0d required bio=4 oc=0", bio[0], oc[0]);
        end
    endtask

    task automatic test_extras;
        int a, w;
        do_reset;
        push(0, 3'd0, 1'b1, 1'b0, 1'b0, a, w);
        push(0, 3'd4, 1'b0, 1'b1, 1'b1, a, w);
        wait_events(0, 2);
        total++;
        if (get_ev(0, 0).runs !== 3'd1 || get_ev(0, 1).runs !== 3'd5) begin
            bad++;
            $display("FAIL penalty_runs got=%0d,%0d required=1,5", get_ev(0, 0).runs, get_ev(0, 1).runs);
        end
        total++;
        if (get_ev(0, 0).bio !== 3'd0 || get_ev(0, 1).bio !== 3'd0 ||
            get_ev(0, 0).ocomp !== 1'b0 || get_ev(0, 1).ocomp !== 1'b0) begin
            bad++;
            $display("FAIL extras_no_count bio=%0d,%0d ocomp=%b,%b required 0,0 0,0",
                     get_ev(0, 0).bio, get_ev(0, 1).bio, get_ev(0, 0).ocomp, get_ev(0, 1).ocomp);
        end
        total++;
        if (get_ev(0, 0).wk !== 1'b0 || get_ev(0, 1).wk !== 1'b1) begin
            bad++;
            $display("FAIL extras_wicket got=%b,%b required=0,1", get_ev(0, 0).wk, get_ev(0, 1).wk);
        end
    endtask

    task automatic test_over;
        int a, w;
        logic [2:0] exp_bio[7];
        logic [7:0] exp_oc[7];
        exp_bio = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
        exp_oc  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
        do_reset;
        for (int i = 0; i < 6; i++) push(0, 3'(i + 1), 1'b0, 1'b0, 1'b0, a, w);
        push(0, 3'd2, 1'b1, 1'b0, 1'b0, a, w);
        wait_events(0, 7);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (get_ev(0, i).bio !== exp_bio[i] || get_ev(0, i).oc !== exp_oc[i] ||
                get_ev(0, i).ocomp !== (i == 5)) begin
                bad++;
                $display("FAIL over_track idx=%0d bio=%0d oc=%0d ocomp=%b required bio=%0d oc=%0d ocomp=%b",
                         i, get_ev(0, i).bio, get_ev(0, i).oc, get_ev(0, i).ocomp,
                         exp_bio[i], exp_oc[i], (i == 5));
            end
        end
        total++;
        if (get_ev(0, 6).runs !== 3'd3) begin
            bad++;
            $display("FAIL wide_runs got=%0d required=3", get_ev(0, 6).runs);
        end
    endtask

    task automatic test_innings;
        int a, w;
        do_reset;
        for (int i = 0; i < 6; i++) push(1, 3'd1, 1'b0, 1'b0, 1'b0, a, w);
        wait_events(1, 6);
        total++;
        if (get_ev(1, 4).idone !== 1'b0 || get_ev(1, 5).idone !== 1'b1 ||
            get_ev(1, 5).ocomp !== 1'b1 || get_ev(1, 5).oc !== 8'd1) begin
            bad++;
            $display("FAIL innings_done idone5=%b idone6=%b ocomp=%b oc=%0d required 0 1 1 1",
                     get_ev(1, 4).idone, get_ev(1, 5).idone, get_ev(1, 5).ocomp, get_ev(1, 5).oc);
        end
        @(negedge clk);
        total++;
        if (b1.entry_ready !== 1'b0 || errs[1] != 0) begin
            bad++;
            $display("FAIL done_ready ready=%b errs=%0d required 0 0", b1.entry_ready, errs[1]);
        end
        offer(1, 3'd2, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        total++;
        if (errs[1] != 1 || qsize(1) != 6) begin
            bad++;
            $display("FAIL done_reject errs=%0d pulses=%0d required 1 6", errs[1], qsize(1));
        end
    endtask

    task automatic test_backpressure;
        int a, w, a_f, e;
        int stall;
        logic [2:0] exp_r[6];
        exp_r = '{3'd3, 3'd1, 3'd2, 3'd5, 3'd6, 3'd4};
        do_reset;
        stall = 0;
        for (int i = 0; i < 5; i++) begin
            push(2, exp_r[i], 1'b0, 1'b0, 1'b0, a, w);
            stall += w;
        end
        total++;
        if (stall != 0) begin
            bad++;
            $display("FAIL fill_stall got=%0d required=0", stall);
        end
        @(negedge clk);
        total++;
        if (b2.entry_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready got=%b required=0", b2.entry_ready);
        end
        push(2, exp_r[5], 1'b0, 1'b0, 1'b0, a_f, w);
        total++;
        if (w == 0 || qsize(2) < 2 || a_f - get_ev(2, 1).cyc != 1) begin
            bad++;
            $display("FAIL accept_after_pop waits=%0d pulses=%0d delta=%0d required waits>0 pulses>=2 delta=1",
                     w, qsize(2), a_f - get_ev(2, 1).cyc);
        end
        wait_events(2, 6);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (get_ev(2, i).runs !== exp_r[i]) begin
                bad++;
                $display("FAIL order idx=%0d got=%0d required=%0d", i, get_ev(2, i).runs, exp_r[i]);
            end
        end
        total++;
        if (get_ev(2, 1).cyc - get_ev(2, 0).cyc != 13) begin
            bad++;
            $display("FAIL gap_spacing got=%0d required=13", get_ev(2, 1).cyc - get_ev(2, 0).cyc);
        end
        e = errs[2];
        push(2, 3'd7, 1'b0, 1'b0, 1'b0, a, w);
        push(2, 3'd2, 1'b1, 1'b1, 1'b0, a, w);
        repeat (20) @(negedge clk);
        total++;
        if (errs[2] != e + 2 || qsize(2) != 6) begin
            bad++;
            $display("FAIL invalid_entry errs=%0d pulses=%0d required %0d 6", errs[2], qsize(2), e + 2);
        end
    endtask

`ifdef FREE_HIT_EN
    task automatic test_free_hit;
        int a, w;
        logic fh_exp[4];
        logic wk_exp[4];
        fh_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
        wk_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset;
        push(0, 3'd0, 1'b0, 1'b1, 1'b0, a, w);
        push(0, 3'd0, 1'b1, 1'b0, 1'b1, a, w);
        push(0, 3'd2, 1'b0, 1'b0, 1'b1, a, w);
        push(0, 3'd3, 1'b0, 1'b0, 1'b1, a, w);
        wait_events(0, 4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (get_ev(0, i).fhit !== fh_exp[i] || get_ev(0, i).wk !== wk_exp[i]) begin
                bad++;
                $display("FAIL free_hit idx=%0d fh=%b wk=%b required fh=%b wk=%b",
                         i, get_ev(0, i).fhit, get_ev(0, i).wk, fh_exp[i], wk_exp[i]);
            end
        end
    endtask
`endif

    initial begin
        for (int unsigned i = 0; i < 3; i++) drive(int'(i), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        errs[0] = 0; errs[1] = 0; errs[2] = 0;
        repeat (2) @(negedge clk);
        test_reset;
        test_reset_abort;
        test_legal;
        test_extras;
        test_over;
        test_innings;
        test_backpressure;
`ifdef FREE_HIT_EN
        test_free_hit;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
